// File: rtl/pattern_playback_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_playback_sequencer
//
// Purpose:
//   Feeds the 00/11 consecutive-bit detector from one of two sources:
//     - live debounced button pulses (manual mode, IDLE only), or
//     - a latched bit sequence of 1..MAX_LEN bits, played LSB first, with one
//       bit issued every STEP_CYCLES clocks.
//   Also counts detector hits since the last accepted start, and reports
//   busy/done for the playback run.
//
// Optional feature (macro SEQ_LOOP_EN):
//   When defined, playback wraps from the last bit back to bit 0 and runs until
//   stop_pulse or reset. The DONE state is never entered and done stays 0.
//   When undefined, a single pass is played and done pulses at the end.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   btn0_pulse   in   manual '0' entry (1-cycle pulse)
//   btn2_pulse   in   manual '1' entry (1-cycle pulse)
//   start_pulse  in   begin playback (1-cycle pulse)
//   stop_pulse   in   abort playback (1-cycle pulse)
//   seq_data     in   sequence bits, bit 0 played first
//   seq_len      in   number of bits to play, 1..MAX_LEN
//   det_00       in   detector 00 hit pulse
//   det_11       in   detector 11 hit pulse
//   bit0_pulse   out  '0' entry to the detector
//   bit1_pulse   out  '1' entry to the detector
//   busy         out  playback in progress
//   done         out  1-cycle pulse when a run completes normally
//   bit_index    out  index of the bit currently or last issued
//   cnt_00       out  saturating count of 00 hits since last accepted start
//   cnt_11       out  saturating count of 11 hits since last accepted start
// ---------------------------------------------------------------------------
module pattern_playback_sequencer #(
    parameter int MAX_LEN     = 16,
    parameter int LEN_W       = 5,
    parameter int STEP_CYCLES = 50_000_000,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn0_pulse,
    input  logic               btn2_pulse,
    input  logic               start_pulse,
    input  logic               stop_pulse,
    input  logic [MAX_LEN-1:0] seq_data,
    input  logic [LEN_W-1:0]   seq_len,
    input  logic               det_00,
    input  logic               det_11,
    output logic               bit0_pulse,
    output logic               bit1_pulse,
    output logic               busy,
    output logic               done,
    output logic [LEN_W-1:0]   bit_index,
    output logic [CNT_W-1:0]   cnt_00,
    output logic [CNT_W-1:0]   cnt_11
);

    // Timer counts 0..STEP_CYCLES-2 inside WAIT.
    localparam int TMR_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [MAX_LEN-1:0] seq_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx_q;
    logic [TMR_W-1:0]   tmr_q;
    logic               b0_q;
    logic               b1_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   c00_q;
    logic [CNT_W-1:0]   c11_q;
    logic [CNT_W-1:0]   c00_d;
    logic [CNT_W-1:0]   c11_d;

    logic               len_ok;
    logic               start_ok;
    logic               last_bit;
    logic               step_end;
    logic [LEN_W-1:0]   idx_inc;
    logic               next_bit;

    assign len_ok   = (seq_len != '0) && (seq_len <= LEN_W'(MAX_LEN));
    assign start_ok = (state_q == S_IDLE) && start_pulse && len_ok;
    assign last_bit = (idx_q == (len_q - LEN_W'(1)));
    assign step_end = (tmr_q == TMR_W'(STEP_CYCLES - 2));
    assign idx_inc  = idx_q + LEN_W'(1);

    // Bit to issue on the next step; explicit mux keeps the index width
    // independent of the sequence width.
    always_comb begin
        next_bit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_inc == LEN_W'(i)) begin
                next_bit = seq_q[i];
            end
        end
    end

    // Hit counters: an accepted start clears them and swallows a same-cycle hit.
    always_comb begin
        c00_d = c00_q;
        c11_d = c11_q;
        if (start_ok) begin
            c00_d = '0;
            c11_d = '0;
        end else begin
            if (det_00 && (c00_q != '1)) c00_d = c00_q + CNT_W'(1);
            if (det_11 && (c11_q != '1)) c11_d = c11_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c00_q <= '0;
            c11_q <= '0;
        end else begin
            c00_q <= c00_d;
            c11_q <= c11_d;
        end
    end

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            tmr_q   <= '0;
            b0_q    <= 1'b0;
            b1_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Pulses default low every cycle.
            b0_q   <= 1'b0;
            b1_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        seq_q   <= seq_data;
                        len_q   <= seq_len;
                        idx_q   <= '0;
                        b0_q    <= ~seq_data[0];
                        b1_q    <= seq_data[0];
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end else if (btn0_pulse ^ btn2_pulse) begin
                        // Simultaneous buttons are ambiguous and dropped.
                        b0_q <= btn0_pulse;
                        b1_q <= btn2_pulse;
                    end
                end
                S_ISSUE: begin
                    if (stop_pulse) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmr_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (stop_pulse) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (step_end) begin
                        if (last_bit) begin
`ifdef SEQ_LOOP_EN
                            idx_q   <= '0;
                            b0_q    <= ~seq_q[0];
                            b1_q    <= seq_q[0];
                            state_q <= S_ISSUE;
`else
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
`endif
                        end else begin
                            idx_q   <= idx_inc;
                            b0_q    <= ~next_bit;
                            b1_q    <= next_bit;
                            state_q <= S_ISSUE;
                        end
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bit0_pulse = b0_q;
    assign bit1_pulse = b1_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign bit_index  = idx_q;
    assign cnt_00     = c00_q;
    assign cnt_11     = c11_q;

endmodule

// File: tb/tb_pattern_playback_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pattern_playback_sequencer
//
// Self-checking bench for pattern_playback_sequencer (STEP_CYCLES=4,
// MAX_LEN=16, CNT_W=8). The reference model describes a run as a timeline:
// a start accepted in cycle T issues bit k at T+1+k*STEP and completes at
// T+1+len*STEP; outputs are derived from the cycle offset into that timeline.
// ---------------------------------------------------------------------------
module tb_pattern_playback_sequencer;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int STEP    = 4;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               btn0_pulse = 1'b0;
    logic               btn2_pulse = 1'b0;
    logic               start_pulse = 1'b0;
    logic               stop_pulse = 1'b0;
    logic [MAX_LEN-1:0] seq_data = '0;
    logic [LEN_W-1:0]   seq_len = '0;
    logic               det_00 = 1'b0;
    logic               det_11 = 1'b0;
    logic               bit0_pulse;
    logic               bit1_pulse;
    logic               busy;
    logic               done;
    logic [LEN_W-1:0]   bit_index;
    logic [CNT_W-1:0]   cnt_00;
    logic [CNT_W-1:0]   cnt_11;

    pattern_playback_sequencer #(
        .MAX_LEN    (MAX_LEN),
        .LEN_W      (LEN_W),
        .STEP_CYCLES(STEP),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn0_pulse (btn0_pulse),
        .btn2_pulse (btn2_pulse),
        .start_pulse(start_pulse),
        .stop_pulse (stop_pulse),
        .seq_data   (seq_data),
        .seq_len    (seq_len),
        .det_00     (det_00),
        .det_11     (det_11),
        .bit0_pulse (bit0_pulse),
        .bit1_pulse (bit1_pulse),
        .busy       (busy),
        .done       (done),
        .bit_index  (bit_index),
        .cnt_00     (cnt_00),
        .cnt_11     (cnt_11)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    int               cyc = 0;
    bit               m_active = 1'b0;
    int               m_T = 0;
    int               m_len = 0;
    logic [MAX_LEN-1:0] m_data = '0;
    int               m_idx = 0;
    int               m_c00 = 0;
    int               m_c11 = 0;
    bit               e_b0, e_b1, e_busy, e_done;

    task automatic chk(input string tag, input int observed, input int expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, observed, expected);
        end
    endtask

    // One clock: apply held inputs at the edge, advance the model, compare,
    // then clear the one-cycle pulse inputs.
    task automatic tick();
        int rel_c;
        int r;
        int k;
        bit accept;
        @(posedge clk);
        #1;
        accept = 1'b0;
        if (reset) begin
            m_active = 1'b0;
            m_idx    = 0;
            m_c00    = 0;
            m_c11    = 0;
            e_b0 = 1'b0; e_b1 = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        end else begin
            e_b0 = 1'b0; e_b1 = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            if (m_active) begin
                rel_c = cyc - m_T - 1;
`ifdef SEQ_LOOP_EN
                if (stop_pulse) m_active = 1'b0;
`else
                if (rel_c < m_len * STEP) begin
                    if (stop_pulse) m_active = 1'b0;
                end else begin
                    m_active = 1'b0; // completion cycle has passed
                end
`endif
            end else if (start_pulse && seq_len >= 1 && seq_len <= MAX_LEN) begin
                accept   = 1'b1;
                m_active = 1'b1;
                m_T      = cyc;
                m_len    = int'(seq_len);
                m_data   = seq_data;
                m_idx    = 0;
                $display("run start cycle=%0d len=%0d data=%04h", cyc, m_len, m_data);
            end else if (btn0_pulse && !btn2_pulse) begin
                e_b0 = 1'b1;
            end else if (btn2_pulse && !btn0_pulse) begin
                e_b1 = 1'b1;
            end

            if (accept) begin
                m_c00 = 0;
                m_c11 = 0;
            end else begin
                if (det_00 && m_c00 < 255) m_c00++;
                if (det_11 && m_c11 < 255) m_c11++;
            end

            if (m_active) begin
                r = cyc - m_T; // offset of the next cycle from the first issue
`ifdef SEQ_LOOP_EN
                r = r % (m_len * STEP);
`endif
                if (r < m_len * STEP) begin
                    e_busy = 1'b1;
                    if (r % STEP == 0) begin
                        k = r / STEP;
                        m_idx = k;
                        if (m_data[k]) e_b1 = 1'b1;
                        else e_b0 = 1'b1;
                    end
                end else begin
                    e_done = 1'b1;
                end
            end
        end
        cyc++;

        chk("bit0_pulse", int'(bit0_pulse), int'(e_b0));
        chk("bit1_pulse", int'(bit1_pulse), int'(e_b1));
        chk("exclusive",  int'(bit0_pulse & bit1_pulse), 0);
        chk("busy",       int'(busy), int'(e_busy));
        chk("done",       int'(done), int'(e_done));
        chk("bit_index",  int'(bit_index), m_idx);
        chk("cnt_00",     int'(cnt_00), m_c00);
        chk("cnt_11",     int'(cnt_11), m_c11);

        btn0_pulse  = 1'b0;
        btn2_pulse  = 1'b0;
        start_pulse = 1'b0;
        stop_pulse  = 1'b0;
        det_00      = 1'b0;
        det_11      = 1'b0;
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Manual entry: 0,0,1,1 then a simultaneous pair
        btn0_pulse = 1'b1; tick(); tick();
        btn0_pulse = 1'b1; tick(); tick();
        btn2_pulse = 1'b1; tick(); tick();
        btn2_pulse = 1'b1; tick(); tick();
        btn0_pulse = 1'b1; btn2_pulse = 1'b1; tick(); tick();
        $display("manual entry checked");

        // Playback 0110, len 4, with stray buttons and a detector hit
        seq_data = 16'b0110; seq_len = 5'd4; start_pulse = 1'b1; tick();
        for (int i = 1; i <= 20; i++) begin
            if (i == 3)  btn0_pulse = 1'b1;
            if (i == 7)  btn2_pulse = 1'b1;
            if (i == 10) det_11 = 1'b1;
            tick();
        end

        // Rejected starts
        seq_len = 5'd0; start_pulse = 1'b1; tick();
        repeat (4) tick();
        seq_len = 5'd17; start_pulse = 1'b1; tick();
        repeat (4) tick();

        // Abort 2 cycles after the second bit
        seq_data = 16'hA5C3; seq_len = 5'd4; start_pulse = 1'b1; tick();
        repeat (6) tick();
        stop_pulse = 1'b1; tick();
        repeat (12) tick();

        // Reset mid-WAIT
        seq_data = 16'h00FF; seq_len = 5'd8; start_pulse = 1'b1; tick();
        repeat (3) tick();
        reset = 1'b1; tick();
        reset = 1'b0; tick(); tick();

        // Saturation, then a start clears the counter
        for (int i = 0; i < 300; i++) begin
            det_00 = 1'b1;
            tick();
        end
        seq_data = 16'h0001; seq_len = 5'd1; start_pulse = 1'b1; det_00 = 1'b1; tick();
        repeat (8) tick();

        // Full-length run
        seq_data = 16'h9F31; seq_len = 5'd16; start_pulse = 1'b1; tick();
        repeat (70) tick();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            btn0_pulse  = ($urandom_range(0, 7) == 0);
            btn2_pulse  = ($urandom_range(0, 7) == 0);
            start_pulse = ($urandom_range(0, 39) == 0);
            stop_pulse  = ($urandom_range(0, 149) == 0);
            det_00      = ($urandom_range(0, 5) == 0);
            det_11      = ($urandom_range(0, 5) == 0);
            seq_len     = LEN_W'($urandom_range(0, 18));
            seq_data    = MAX_LEN'($urandom);
            reset       = ($urandom_range(0, 999) == 0);
            tick();
            reset = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
